// File: rtl/data_path_pkg.sv
// Shared constants for the phase-1 datapath: data width and bus-source select indices.
package data_path_pkg;

  localparam int DATA_W  = 32;
  localparam int NUM_SRC = 24;

  typedef logic [DATA_W-1:0] word_t;

  localparam int SEL_R0     = 0;
  localparam int SEL_R15    = 15;
  localparam int SEL_HI     = 16;
  localparam int SEL_LO     = 17;
  localparam int SEL_ZHI    = 18;
  localparam int SEL_ZLO    = 19;
  localparam int SEL_PC     = 20;
  localparam int SEL_MDR    = 21;
  localparam int SEL_INPORT = 22;
  localparam int SEL_CSIGN  = 23;

endpackage

// File: rtl/data_path_reg32.sv
// 32-bit register with load enable and asynchronous active-low clear.
module reg32
  import data_path_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_clr_n,
  input  logic  i_ld,
  input  word_t i_d,
  output word_t o_q
);

  word_t r_q;

  // Capture on load, hold otherwise.
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_q <= 32'h0000_0000;
    end else if (i_ld) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/data_path.sv
// Phase-1 CPU datapath: shared 32-bit bus, 25 registers and a logic ALU feeding ZHI/ZLO.
module data_path
  import data_path_pkg::*;
(
  input  logic [31:0] Mdatain,
  input  logic [31:0] encIn,
  input  logic        Clock,
  input  logic        Clear,
  input  logic        Read,
  input  logic        R0in,
  input  logic        R1in,
  input  logic        R2in,
  input  logic        R3in,
  input  logic        R4in,
  input  logic        R5in,
  input  logic        R6in,
  input  logic        R7in,
  input  logic        R8in,
  input  logic        R9in,
  input  logic        R10in,
  input  logic        R11in,
  input  logic        R12in,
  input  logic        R13in,
  input  logic        R14in,
  input  logic        R15in,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        ZHIin,
  input  logic        ZLOin,
  input  logic        PCin,
  input  logic        INPORTin,
  input  logic        CSIGNin,
  input  logic        MDRin,
  input  logic        Yin,
  output logic [31:0] R0,
  output logic [31:0] R1,
  output logic [31:0] R2,
  output logic [31:0] R3,
  output logic [31:0] R4,
  output logic [31:0] R5,
  output logic [31:0] R6,
  output logic [31:0] R7,
  output logic [31:0] R8,
  output logic [31:0] R9,
  output logic [31:0] R10,
  output logic [31:0] R11,
  output logic [31:0] R12,
  output logic [31:0] R13,
  output logic [31:0] R14,
  output logic [31:0] R15,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] ZHI,
  output logic [31:0] ZLO,
  output logic [31:0] PC,
  output logic [31:0] MDR,
  output logic [31:0] INPORT,
  output logic [31:0] CSIGN,
  output logic [31:0] RY,
  input  logic        NOT,
  input  logic        OR,
  input  logic        AND,
  output logic [31:0] busMuxOut
);

  logic [15:0]  w_gpr_ld;
  word_t        w_gpr [0:15];
  word_t        w_src [0:NUM_SRC-1];
  word_t        w_bus;
  word_t        w_alu_lo;
  logic [63:0]  w_alu_c;
  word_t        w_mdr_d;
  word_t        w_hi, w_lo, w_zhi, w_zlo, w_pc, w_mdr, w_inport, w_csign, w_y;

  assign w_gpr_ld = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                     R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

  for (genvar g = 0; g < 16; g++) begin : g_gpr
    reg32 u_gpr (.i_clk(Clock), .i_clr_n(Clear), .i_ld(w_gpr_ld[g]), .i_d(w_bus), .o_q(w_gpr[g]));
    assign w_src[SEL_R0 + g] = w_gpr[g];
  end

  reg32 u_hi     (.i_clk(Clock), .i_clr_n(Clear), .i_ld(HIin),     .i_d(w_bus),            .o_q(w_hi));
  reg32 u_lo     (.i_clk(Clock), .i_clr_n(Clear), .i_ld(LOin),     .i_d(w_bus),            .o_q(w_lo));
  reg32 u_zhi    (.i_clk(Clock), .i_clr_n(Clear), .i_ld(ZHIin),    .i_d(w_alu_c[63:32]),   .o_q(w_zhi));
  reg32 u_zlo    (.i_clk(Clock), .i_clr_n(Clear), .i_ld(ZLOin),    .i_d(w_alu_c[31:0]),    .o_q(w_zlo));
  reg32 u_pc     (.i_clk(Clock), .i_clr_n(Clear), .i_ld(PCin),     .i_d(w_bus),            .o_q(w_pc));
  reg32 u_mdr    (.i_clk(Clock), .i_clr_n(Clear), .i_ld(MDRin),    .i_d(w_mdr_d),          .o_q(w_mdr));
  reg32 u_inport (.i_clk(Clock), .i_clr_n(Clear), .i_ld(INPORTin), .i_d(w_bus),            .o_q(w_inport));
  reg32 u_csign  (.i_clk(Clock), .i_clr_n(Clear), .i_ld(CSIGNin),  .i_d(w_bus),            .o_q(w_csign));
  reg32 u_y      (.i_clk(Clock), .i_clr_n(Clear), .i_ld(Yin),      .i_d(w_bus),            .o_q(w_y));

  assign w_src[SEL_HI]     = w_hi;
  assign w_src[SEL_LO]     = w_lo;
  assign w_src[SEL_ZHI]    = w_zhi;
  assign w_src[SEL_ZLO]    = w_zlo;
  assign w_src[SEL_PC]     = w_pc;
  assign w_src[SEL_MDR]    = w_mdr;
  assign w_src[SEL_INPORT] = w_inport;
  assign w_src[SEL_CSIGN]  = w_csign;

  assign w_mdr_d = Read ? Mdatain : w_bus;

  // Priority bus mux: scanning downward lets the lowest set select bit win; bits 24-31 never drive.
  always_comb begin
    w_bus = 32'h0000_0000;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (encIn[i]) begin
        w_bus = w_src[i];
      end else begin
        w_bus = w_bus;
      end
    end
  end

  // Logic ALU on Y and the bus; upper half of the result is always zero for these ops.
  always_comb begin
    w_alu_lo = 32'h0000_0000;
    if (AND) begin
      w_alu_lo = w_y & w_bus;
    end else if (OR) begin
      w_alu_lo = w_y | w_bus;
    end else if (NOT) begin
      w_alu_lo = ~w_bus;
    end else begin
      w_alu_lo = 32'h0000_0000;
    end
  end

  assign w_alu_c   = {32'h0000_0000, w_alu_lo};
  assign busMuxOut = w_bus;

  assign R0  = w_gpr[0];
  assign R1  = w_gpr[1];
  assign R2  = w_gpr[2];
  assign R3  = w_gpr[3];
  assign R4  = w_gpr[4];
  assign R5  = w_gpr[5];
  assign R6  = w_gpr[6];
  assign R7  = w_gpr[7];
  assign R8  = w_gpr[8];
  assign R9  = w_gpr[9];
  assign R10 = w_gpr[10];
  assign R11 = w_gpr[11];
  assign R12 = w_gpr[12];
  assign R13 = w_gpr[13];
  assign R14 = w_gpr[14];
  assign R15 = w_gpr[15];
  assign HI     = w_hi;
  assign LO     = w_lo;
  assign ZHI    = w_zhi;
  assign ZLO    = w_zlo;
  assign PC     = w_pc;
  assign MDR    = w_mdr;
  assign INPORT = w_inport;
  assign CSIGN  = w_csign;
  assign RY     = w_y;

endmodule

// File: tb/tb_data_path.sv
// Randomized and directed bench for data_path against a behavioural register-file model.
module tb_data_path;

  logic        Clock = 1'b0;
  logic        Clear;
  logic [31:0] Mdatain;
  logic [31:0] encIn;
  logic        Read;
  logic        op_not, op_or, op_and;
  logic [24:0] en;
  logic [31:0] q [0:24];
  logic [31:0] busMuxOut;

  // Model state: index 0-15 R, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 INPORT, 23 CSIGN, 24 Y.
  logic [31:0] mreg [0:24];
  int          checks = 0;
  int          errors = 0;

  always #5 Clock = ~Clock;

  data_path dut (
    .Mdatain(Mdatain), .encIn(encIn), .Clock(Clock), .Clear(Clear), .Read(Read),
    .R0in(en[0]), .R1in(en[1]), .R2in(en[2]), .R3in(en[3]), .R4in(en[4]), .R5in(en[5]),
    .R6in(en[6]), .R7in(en[7]), .R8in(en[8]), .R9in(en[9]), .R10in(en[10]), .R11in(en[11]),
    .R12in(en[12]), .R13in(en[13]), .R14in(en[14]), .R15in(en[15]),
    .HIin(en[16]), .LOin(en[17]), .ZHIin(en[18]), .ZLOin(en[19]), .PCin(en[20]),
    .INPORTin(en[22]), .CSIGNin(en[23]), .MDRin(en[21]), .Yin(en[24]),
    .R0(q[0]), .R1(q[1]), .R2(q[2]), .R3(q[3]), .R4(q[4]), .R5(q[5]), .R6(q[6]), .R7(q[7]),
    .R8(q[8]), .R9(q[9]), .R10(q[10]), .R11(q[11]), .R12(q[12]), .R13(q[13]), .R14(q[14]),
    .R15(q[15]), .HI(q[16]), .LO(q[17]), .ZHI(q[18]), .ZLO(q[19]), .PC(q[20]), .MDR(q[21]),
    .INPORT(q[22]), .CSIGN(q[23]), .RY(q[24]),
    .NOT(op_not), .OR(op_or), .AND(op_and), .busMuxOut(busMuxOut)
  );

  function automatic logic [31:0] model_bus(input logic [31:0] sel);
    for (int i = 0; i < 24; i++) begin
      if (sel[i]) return mreg[i];
    end
    return 32'h0;
  endfunction

  function automatic logic [63:0] model_alu(input logic [31:0] a, input logic [31:0] b);
    if (op_and) return {32'h0, a & b};
    if (op_or)  return {32'h0, a | b};
    if (op_not) return {32'h0, ~b};
    return 64'h0;
  endfunction

  // Reference register file: async clear, otherwise load-enabled capture of pre-edge values.
  always @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      for (int i = 0; i < 25; i++) mreg[i] <= 32'h0;
    end else begin
      logic [31:0] b;
      logic [63:0] c;
      b = model_bus(encIn);
      c = model_alu(mreg[24], b);
      for (int i = 0; i < 25; i++) begin
        if (en[i]) begin
          if (i == 18)      mreg[i] <= c[63:32];
          else if (i == 19) mreg[i] <= c[31:0];
          else if (i == 21) mreg[i] <= Read ? Mdatain : b;
          else              mreg[i] <= b;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of every register and the bus against the model.
  always @(negedge Clock) begin
    for (int i = 0; i < 25; i++) check($sformatf("reg[%0d]", i), q[i], mreg[i]);
    check("bus", busMuxOut, model_bus(encIn));
  end

  task automatic idle();
    en = 25'h0; op_and = 1'b0; op_or = 1'b0; op_not = 1'b0; Read = 1'b0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
    #1;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1'b1; en[21] = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 25; i++) mreg[i] = 32'h0;
    Clear = 1'b0; Mdatain = 32'h0; encIn = 32'h0;
    idle();
    repeat (2) @(posedge Clock);
    #1;
    check("reset R0", q[0], 32'h0);
    check("reset bus", busMuxOut, 32'h0);
    Clear = 1'b1;
    tick();

    // MDR load and Y capture
    load_mdr(32'hFFFF_0000);
    check("mdr load", q[21], 32'hFFFF_0000);
    encIn = 32'h0020_0000; #1;
    check("bus mdr", busMuxOut, 32'hFFFF_0000);
    en[24] = 1'b1; tick();
    check("y capture", q[24], 32'hFFFF_0000);

    // AND
    load_mdr(32'h0000_FFFF);
    op_and = 1'b1; en[19] = 1'b1; tick();
    check("and zlo", q[19], 32'h0000_0000);
    encIn = 32'h0008_0000; #1;
    check("bus zlo", busMuxOut, 32'h0000_0000);

    // OR, NOT, ZHI
    encIn = 32'h0020_0000;
    load_mdr(32'hF0F0_F0F0);
    en[24] = 1'b1; tick();
    load_mdr(32'h0F0F_00FF);
    op_or = 1'b1; en[19] = 1'b1; tick();
    check("or zlo", q[19], 32'hFFFF_F0FF);
    load_mdr(32'h1234_5678);
    op_not = 1'b1; en[19] = 1'b1; tick();
    check("not zlo", q[19], 32'hEDCB_A987);
    op_not = 1'b1; en[18] = 1'b1; tick();
    check("zhi zero", q[18], 32'h0);

    // Same-edge read/write of ZLO
    encIn = 32'h0008_0000;
    op_not = 1'b1; en[19] = 1'b1; tick();
    check("zlo self", q[19], 32'h1234_5678);

    // Register transfer and priority
    encIn = 32'h0020_0000;
    load_mdr(32'hA5A5_A5A5);
    en[5] = 1'b1; tick();
    encIn = 32'h0000_0020; en[9] = 1'b1; tick();
    check("r9 copy", q[9], 32'hA5A5_A5A5);
    encIn = 32'h0020_0000;
    load_mdr(32'h1111_1111);
    en[9] = 1'b1; tick();
    encIn = 32'h0000_0220; #1;
    check("priority", busMuxOut, 32'hA5A5_A5A5);
    encIn = 32'hFF00_0000; #1;
    check("unused sel", busMuxOut, 32'h0);
    encIn = 32'h0100_0020; #1;
    check("unused+r5", busMuxOut, 32'hA5A5_A5A5);

    // No-op holds
    for (int i = 0; i < 4; i++) begin
      Mdatain = $urandom;
      tick();
    end
    check("mdr hold", q[21], 32'h1111_1111);
    check("r5 hold", q[5], 32'hA5A5_A5A5);

    // Randomized traffic with occasional mid-run clears
    for (int n = 0; n < 400; n++) begin
      Mdatain = $urandom;
      Read    = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       encIn = 32'h0;
        1:       encIn = $urandom;
        default: encIn = 32'h1 << $urandom_range(0, 31);
      endcase
      for (int i = 0; i < 25; i++) en[i] = ($urandom_range(0, 5) == 0);
      op_and = ($urandom_range(0, 3) == 0);
      op_or  = ($urandom_range(0, 2) == 0);
      op_not = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 60) == 0) begin
        Clear = 1'b0; #1; Clear = 1'b1;
      end
      tick();
    end

    // Reset mid-run
    Clear = 1'b0; encIn = 32'h0; #1;
    for (int i = 0; i < 25; i++) check($sformatf("clear reg[%0d]", i), q[i], 32'h0);
    check("clear bus", busMuxOut, 32'h0);
    @(posedge Clock); #1;
    Clear = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
